minibus_nslave_decoder: RTL and testbench

//  Parametrised N-slave minibus decoder: accepts one master request, matches the address against
//  a base/mask table and routes it to exactly one slave select. Holds the request stable until the

---
 rtl/minibus_pkg.sv | 17 +
 rtl/minibus_addr_match.sv | 28 ++
 rtl/minibus_nslave_decoder.sv | 137 +++++++++++++
 tb/tb_minibus_nslave_decoder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/minibus_pkg.sv
// Shared minibus types and constants: decoder state encoding and slave-count limits.
package minibus_pkg;

   localparam int unsigned MINIBUS_MAX_SLAVES = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } minibus_dec_state_e;

   // Index width for a slave table, at least one bit so a single-slave build still has a port.
   function automatic int unsigned minibus_idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/minibus_addr_match.sv
// Base/mask address compare across the slave table with lowest-index-wins priority.
module minibus_addr_match
   import minibus_pkg::*;
#(
   parameter int unsigned N_SLAVES = 4,
   parameter int unsigned AW = 32,
   parameter logic [N_SLAVES*AW-1:0] SLAVE_BASE = '0,
   parameter logic [N_SLAVES*AW-1:0] SLAVE_MASK = '0,
   localparam int unsigned IW = minibus_idx_w(N_SLAVES)
) (
   input  logic [AW-1:0] addr,
   output logic          hit,
   output logic [IW-1:0] idx
);

   // Scan from the top down so the lowest matching index is the last one written.
   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int i = N_SLAVES - 1; i >= 0; i--) begin
         if ((addr & SLAVE_MASK[i*AW +: AW]) == SLAVE_BASE[i*AW +: AW]) begin
            hit = 1'b1;
            idx = IW'(i);
         end
      end
   end

endmodule

// File: rtl/minibus_nslave_decoder.sv
// N-slave minibus decoder: latches one master request, selects the matching slave,
// waits for its response or a timeout, and returns rdata/err to the master.
module minibus_nslave_decoder
   import minibus_pkg::*;
#(
   parameter int unsigned N_SLAVES = 4,
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32,
   parameter logic [N_SLAVES*AW-1:0] SLAVE_BASE =
      {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
   parameter logic [N_SLAVES*AW-1:0] SLAVE_MASK =
      {32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000},
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   m_req_valid,
   input  logic [AW-1:0]          m_addr,
   input  logic                   m_wen,
   input  logic [DW-1:0]          m_wdata,
   input  logic [DW/8-1:0]        m_wstrb,
   output logic                   m_busy,
   output logic                   m_res_valid,
   output logic [DW-1:0]          m_rdata,
   output logic                   m_err,
   output logic [N_SLAVES-1:0]    s_sel,
   output logic [AW-1:0]          s_addr,
   output logic                   s_wen,
   output logic [DW-1:0]          s_wdata,
   output logic [DW/8-1:0]        s_wstrb,
   input  logic [N_SLAVES-1:0]    s_res_ready,
   input  logic [N_SLAVES*DW-1:0] s_rdata,
   input  logic [N_SLAVES-1:0]    s_err
);

   localparam int unsigned IW = minibus_idx_w(N_SLAVES);
   localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

   minibus_dec_state_e state;
   logic [IW-1:0]      idx_q;
   logic [CW-1:0]      cnt;

   logic               dec_hit;
   logic [IW-1:0]      dec_idx;
   logic               sel_ready;
   logic               sel_err;
   logic [DW-1:0]      sel_rdata;
   logic               timeout_hit;

   minibus_addr_match #(
      .N_SLAVES   (N_SLAVES),
      .AW         (AW),
      .SLAVE_BASE (SLAVE_BASE),
      .SLAVE_MASK (SLAVE_MASK)
   ) u_match (
      .addr (m_addr),
      .hit  (dec_hit),
      .idx  (dec_idx)
   );

   // Response view of the latched slave; the counter expires on the TIMEOUT-th ACCESS cycle.
   always_comb begin
      sel_ready   = s_res_ready[idx_q];
      sel_err     = s_err[idx_q];
      sel_rdata   = s_rdata[32'(idx_q)*DW +: DW];
      timeout_hit = (TIMEOUT != 0) && ((32'(cnt) + 32'd1) == TIMEOUT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         idx_q       <= '0;
         cnt         <= '0;
         m_busy      <= 1'b0;
         m_res_valid <= 1'b0;
         m_rdata     <= '0;
         m_err       <= 1'b0;
         s_sel       <= '0;
         s_addr      <= '0;
         s_wen       <= 1'b0;
         s_wdata     <= '0;
         s_wstrb     <= '0;
      end else begin
         m_res_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (m_req_valid) begin
                  s_addr  <= m_addr;
                  s_wen   <= m_wen;
                  s_wdata <= m_wdata;
                  s_wstrb <= m_wstrb;
                  idx_q   <= dec_idx;
                  cnt     <= '0;
                  m_busy  <= 1'b1;
                  if (dec_hit) begin
                     state <= ACCESS;
                     s_sel <= N_SLAVES'(1) << dec_idx;
                  end else begin
                     state       <= RESP;
                     m_res_valid <= 1'b1;
                     m_rdata     <= '0;
                     m_err       <= 1'b1;
                  end
               end
            end
            ACCESS: begin
               // Ready takes precedence over a timeout landing in the same cycle.
               if (sel_ready) begin
                  state       <= RESP;
                  s_sel       <= '0;
                  m_res_valid <= 1'b1;
                  m_rdata     <= s_wen ? '0 : sel_rdata;
                  m_err       <= sel_err;
               end else if (timeout_hit) begin
                  state       <= RESP;
                  s_sel       <= '0;
                  m_res_valid <= 1'b1;
                  m_rdata     <= '0;
                  m_err       <= 1'b1;
               end else if (TIMEOUT != 0) begin
                  cnt <= cnt + CW'(1);
               end
            end
            RESP: begin
               state  <= IDLE;
               m_busy <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               m_busy <= 1'b0;
               s_sel  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_minibus_nslave_decoder.sv
// Self-checking bench for minibus_nslave_decoder: directed scenarios plus randomized traffic
// checked against a transaction-level model of the decode table, latency and response rules.
module tb_minibus_nslave_decoder;

   localparam int unsigned N  = 4;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = DW / 8;
   localparam int unsigned TO = 8;

   // Slave 2 (base 0, mask 0xC000_0000) overlaps slaves 0 and 1; slave 3 owns 0x4xxx_xxxx.
   localparam logic [N*AW-1:0] BASE =
      {32'h4000_0000, 32'h0000_0000, 32'h1000_0000, 32'h0000_0000};
   localparam logic [N*AW-1:0] MASK =
      {32'hF000_0000, 32'hC000_0000, 32'hF000_0000, 32'hF000_0000};

   logic          clk = 1'b0;
   logic          rst;
   logic          m_req_valid;
   logic [AW-1:0] m_addr;
   logic          m_wen;
   logic [DW-1:0] m_wdata;
   logic [SW-1:0] m_wstrb;
   logic          m_busy;
   logic          m_res_valid;
   logic [DW-1:0] m_rdata;
   logic          m_err;
   logic [N-1:0]  s_sel;
   logic [AW-1:0] s_addr;
   logic          s_wen;
   logic [DW-1:0] s_wdata;
   logic [SW-1:0] s_wstrb;
   logic [N-1:0]  s_res_ready;
   logic [N*DW-1:0] s_rdata;
   logic [N-1:0]  s_err;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] last_rd;
   logic          last_err;

   always #5 clk = ~clk;

   minibus_nslave_decoder #(
      .N_SLAVES   (N),
      .AW         (AW),
      .DW         (DW),
      .SLAVE_BASE (BASE),
      .SLAVE_MASK (MASK),
      .TIMEOUT    (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .m_req_valid (m_req_valid),
      .m_addr      (m_addr),
      .m_wen       (m_wen),
      .m_wdata     (m_wdata),
      .m_wstrb     (m_wstrb),
      .m_busy      (m_busy),
      .m_res_valid (m_res_valid),
      .m_rdata     (m_rdata),
      .m_err       (m_err),
      .s_sel       (s_sel),
      .s_addr      (s_addr),
      .s_wen       (s_wen),
      .s_wdata     (s_wdata),
      .s_wstrb     (s_wstrb),
      .s_res_ready (s_res_ready),
      .s_rdata     (s_rdata),
      .s_err       (s_err)
   );

   // Reference decode: first table entry whose masked address equals its base.
   function automatic void model_decode(input logic [AW-1:0] a, output bit hit, output int idx);
      hit = 1'b0;
      idx = 0;
      for (int i = 0; i < int'(N); i++) begin
         if (!hit && ((a & MASK[i*AW +: AW]) == BASE[i*AW +: AW])) begin
            hit = 1'b1;
            idx = i;
         end
      end
   endfunction

   // One master transaction. wait_n = number of selected cycles before the slave is ready
   // (negative = never). pulse re-asserts m_req_valid while busy, which must be ignored.
   task automatic do_txn(input logic [AW-1:0] addr, input logic wen, input logic [DW-1:0] wdata,
                         input logic [SW-1:0] wstrb, input int wait_n,
                         input logic [DW-1:0] rdata, input logic err, input bit pulse);
      bit            hit;
      int            idx;
      int            lat;
      logic [N-1:0]  oh;
      logic [N-1:0]  exp_sel;
      logic [DW-1:0] exp_rd;
      logic          exp_err;
      model_decode(addr, hit, idx);
      oh = hit ? (N'(1) << idx) : '0;
      if (!hit) begin
         lat = 1; exp_rd = '0; exp_err = 1'b1;
      end else if (wait_n >= 0 && wait_n < int'(TO)) begin
         lat = 2 + wait_n; exp_rd = wen ? '0 : rdata; exp_err = err;
      end else begin
         lat = 1 + int'(TO); exp_rd = '0; exp_err = 1'b1;
      end

      @(negedge clk);
      checks++;
      if (m_busy !== 1'b0 || m_res_valid !== 1'b0)
         begin errors++; $display("FAIL idle_state: got busy=%b res_valid=%b expected 0 0", m_busy, m_res_valid); end
      checks++;
      if (m_rdata !== last_rd || m_err !== last_err)
         begin errors++; $display("FAIL resp_hold: got rdata=%h err=%b expected %h %b", m_rdata, m_err, last_rd, last_err); end

      m_req_valid = 1'b1;
      m_addr      = addr;
      m_wen       = wen;
      m_wdata     = wdata;
      m_wstrb     = wstrb;
      for (int i = 0; i < int'(N); i++) s_rdata[i*DW +: DW] = DW'($urandom);
      if (hit) s_rdata[idx*DW +: DW] = rdata;
      s_err       = (N'($urandom) & ~oh) | (err ? oh : '0);
      s_res_ready = N'($urandom) & ~oh;

      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         m_req_valid = (pulse && hit && k == 2);
         m_addr      = AW'($urandom);
         m_wen       = 1'($urandom);
         m_wdata     = DW'($urandom);
         m_wstrb     = SW'($urandom);
         s_res_ready = (N'($urandom) & ~oh) | ((k - 1 == wait_n && k < lat) ? oh : '0);
         exp_sel = (k < lat) ? oh : '0;
         checks++;
         if (s_sel !== exp_sel)
            begin errors++; $display("FAIL s_sel[c%0d]: got %b expected %b", k, s_sel, exp_sel); end
         checks++;
         if (m_res_valid !== 1'(k == lat) || m_busy !== 1'b1)
            begin errors++; $display("FAIL res_timing[c%0d]: got res_valid=%b busy=%b expected %b 1", k, m_res_valid, m_busy, k == lat); end
         if (hit && k < lat) begin
            checks++;
            if (s_addr !== addr || s_wen !== wen || s_wdata !== wdata || s_wstrb !== wstrb)
               begin errors++; $display("FAIL s_latch[c%0d]: got %h %b %h %h expected %h %b %h %h", k, s_addr, s_wen, s_wdata, s_wstrb, addr, wen, wdata, wstrb); end
         end
         if (k == lat) begin
            checks++;
            if (m_rdata !== exp_rd || m_err !== exp_err)
               begin errors++; $display("FAIL response: got rdata=%h err=%b expected %h %b", m_rdata, m_err, exp_rd, exp_err); end
         end
      end
      m_req_valid = 1'b0;
      last_rd  = exp_rd;
      last_err = exp_err;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      m_req_valid = 1'b0; m_addr = '0; m_wen = 1'b0; m_wdata = '0; m_wstrb = '0;
      s_res_ready = '0; s_rdata = '0; s_err = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (s_sel !== '0 || m_busy !== 1'b0 || m_res_valid !== 1'b0)
         begin errors++; $display("FAIL reset_ctrl: got sel=%b busy=%b rv=%b expected 0", s_sel, m_busy, m_res_valid); end
      checks++;
      if (m_rdata !== '0 || m_err !== 1'b0)
         begin errors++; $display("FAIL reset_resp: got %h %b expected 0 0", m_rdata, m_err); end
      checks++;
      if (s_addr !== '0 || s_wen !== 1'b0 || s_wdata !== '0 || s_wstrb !== '0)
         begin errors++; $display("FAIL reset_bus: got %h %b %h %h expected 0", s_addr, s_wen, s_wdata, s_wstrb); end
      rst = 1'b0;
      last_rd = '0;
      last_err = 1'b0;
   endtask

   task automatic test_mapped_read();
      do_txn(32'h1000_0004, 1'b0, DW'($urandom), 4'hF, 0, 32'hCAFE_F00D, 1'b0, 1'b0);
   endtask

   task automatic test_write_wait();
      do_txn(32'h2000_0010, 1'b1, 32'h1234_5678, 4'hF, 5, DW'($urandom), 1'b0, 1'b0);
   endtask

   task automatic test_unmapped();
      do_txn(32'hF000_0000, 1'b0, '0, 4'hF, 0, DW'($urandom), 1'b0, 1'b0);
   endtask

   task automatic test_timeout();
      do_txn(32'h4000_0020, 1'b0, '0, 4'hF, -1, 32'hDEAD_BEEF, 1'b0, 1'b0);
      do_txn(32'h4000_0024, 1'b0, '0, 4'hF, int'(TO) - 1, 32'h0BAD_CAFE, 1'b0, 1'b0);
      do_txn(32'h1000_0028, 1'b0, '0, 4'hF, int'(TO), 32'h5555_AAAA, 1'b0, 1'b0);
   endtask

   task automatic test_overlap();
      do_txn(32'h0000_0040, 1'b0, '0, 4'hF, 2, 32'h0000_0A11, 1'b0, 1'b1);
      do_txn(32'h3000_0000, 1'b0, '0, 4'h3, 1, 32'h0000_0B22, 1'b1, 1'b1);
   endtask

   task automatic test_back_to_back();
      do_txn(32'h1000_0100, 1'b1, 32'hA5A5_0001, 4'h1, 0, '0, 1'b1, 1'b0);
      do_txn(32'hE000_0000, 1'b0, '0, 4'hF, 0, '0, 1'b0, 1'b0);
      do_txn(32'h0000_0200, 1'b0, '0, 4'hF, 0, 32'h7777_0003, 1'b0, 1'b0);
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      m_req_valid = 1'b1; m_addr = 32'h4000_0100; m_wen = 1'b0; m_wdata = '0; m_wstrb = 4'hF;
      s_res_ready = '0;
      @(negedge clk);
      m_req_valid = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (s_sel !== 4'b1000)
         begin errors++; $display("FAIL pre_reset_sel: got %b expected 1000", s_sel); end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (s_sel !== '0 || m_busy !== 1'b0 || m_res_valid !== 1'b0)
         begin errors++; $display("FAIL async_reset: got sel=%b busy=%b rv=%b expected 0", s_sel, m_busy, m_res_valid); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         s_res_ready = N'($urandom);
         checks++;
         if (m_res_valid !== 1'b0 || m_busy !== 1'b0)
            begin errors++; $display("FAIL no_resp_after_reset[%0d]: got rv=%b busy=%b expected 0 0", k, m_res_valid, m_busy); end
      end
      last_rd = '0;
      last_err = 1'b0;
      do_txn(32'h4000_0104, 1'b0, '0, 4'hF, 3, 32'h600D_0001, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         logic [AW-1:0] a;
         int w;
         a = {4'($urandom_range(0, 15)), 28'($urandom)};
         w = int'($urandom_range(0, 11));
         if (w == 11) w = -1;
         do_txn(a, 1'($urandom), DW'($urandom), SW'($urandom), w, DW'($urandom),
                1'($urandom), 1'($urandom));
      end
   endtask

   initial begin
      test_reset();
      test_mapped_read();
      test_write_wait();
      test_unmapped();
      test_timeout();
      test_overlap();
      test_back_to_back();
      test_async_reset();
      test_random();
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
